// File: rtl/fpu_alt_arb.sv
// fpu_alt_arb: round-robin arbiter feeding the two ALT injection ports of the
// FPU cluster. Up to two valid requesters are granted per non-stalled cycle;
// the first found goes to port 0 and the second to port 1. Port strobes and
// data are registered, so a word accepted in cycle N appears in cycle N+1.
// Optional feature macro: FPU_ALT_ARB_PERF_EN adds the perf_grants and
// perf_stalls saturating counters.
module fpu_alt_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 84
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_rdy,
    input  logic               stall,
    output logic [1:0]         ALT_INP,
    output logic [DW-1:0]      ALTDATA0,
    output logic [DW-1:0]      ALTDATA1
`ifdef FPU_ALT_ARB_PERF_EN
    ,
    output logic [15:0]        perf_grants,
    output logic [15:0]        perf_stalls
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Index arithmetic modulo NREQ; offset never exceeds NREQ so one subtract suffices.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offset);
        int s;
        s = 32'(base) + offset;
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    // Counter add that clamps at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, acc} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [IW-1:0] rr;
    logic [IW-1:0] cand_p0;
    logic          grant0_vld_p0, grant1_vld_p0;
    logic [IW-1:0] grant0_idx_p0, grant1_idx_p0;
    logic [DW-1:0] port0_data_p0, port1_data_p0;

    logic [1:0]    alt_inp_p1;
    logic [DW-1:0] alt_data0_p1, alt_data1_p1;

    // ---- stage p0: round-robin search from rr for the first two valid requesters
    always_comb begin
        cand_p0       = '0;
        grant0_vld_p0 = 1'b0;
        grant1_vld_p0 = 1'b0;
        grant0_idx_p0 = '0;
        grant1_idx_p0 = '0;
        req_rdy       = '0;
        if (rst && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                cand_p0 = wrap_idx(rr, k);
                if (req_vld[cand_p0]) begin
                    if (!grant0_vld_p0) begin
                        grant0_vld_p0    = 1'b1;
                        grant0_idx_p0    = cand_p0;
                        req_rdy[cand_p0] = 1'b1;
                    end else if (!grant1_vld_p0) begin
                        grant1_vld_p0    = 1'b1;
                        grant1_idx_p0    = cand_p0;
                        req_rdy[cand_p0] = 1'b1;
                    end
                end
            end
        end
    end

    // Select the granted words for each port.
    always_comb begin
        port0_data_p0 = req_data[grant0_idx_p0*DW +: DW];
        port1_data_p0 = req_data[grant1_idx_p0*DW +: DW];
    end

    // ---- stage p1: register port strobes/data and advance the pointer past the last grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr           <= '0;
            alt_inp_p1   <= '0;
            alt_data0_p1 <= '0;
            alt_data1_p1 <= '0;
        end else begin
            alt_inp_p1 <= {grant1_vld_p0, grant0_vld_p0};
            if (grant0_vld_p0) alt_data0_p1 <= port0_data_p0;
            if (grant1_vld_p0) alt_data1_p1 <= port1_data_p0;
            if (grant0_vld_p0)
                rr <= wrap_idx(grant1_vld_p0 ? grant1_idx_p0 : grant0_idx_p0, 1);
        end
    end

    assign ALT_INP  = alt_inp_p1;
    assign ALTDATA0 = alt_data0_p1;
    assign ALTDATA1 = alt_data1_p1;

`ifdef FPU_ALT_ARB_PERF_EN
    logic [15:0] perf_grants_q, perf_stalls_q;

    // Count accepted words and stalled-with-demand cycles, both saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_grants_q <= sat_add(perf_grants_q, {1'b0, grant0_vld_p0} + {1'b0, grant1_vld_p0});
            if (stall && |req_vld)
                perf_stalls_q <= sat_add(perf_stalls_q, 2'd1);
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fpu_alt_arb.sv
// tb_fpu_alt_arb: directed self-checking bench for fpu_alt_arb (default
// parameters). Perf counter scenario is compiled in with FPU_ALT_ARB_PERF_EN.
module tb_fpu_alt_arb;

    localparam int NREQ = 4;
    localparam int DW   = 84;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_vld;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_rdy;
    logic               stall;
    logic [1:0]         ALT_INP;
    logic [DW-1:0]      ALTDATA0;
    logic [DW-1:0]      ALTDATA1;
`ifdef FPU_ALT_ARB_PERF_EN
    logic [15:0]        perf_grants;
    logic [15:0]        perf_stalls;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] w [NREQ];

    fpu_alt_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .stall    (stall),
        .ALT_INP  (ALT_INP),
        .ALTDATA0 (ALTDATA0),
        .ALTDATA1 (ALTDATA1)
`ifdef FPU_ALT_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_word(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        req_vld = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_word(i, w[i]);
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b00) begin errors++; $display("FAIL reset_alt_inp got=%b exp=%b", ALT_INP, 2'b00); end
        checks++;
        if (ALTDATA0 !== '0) begin errors++; $display("FAIL reset_data0 got=%h exp=0", ALTDATA0); end
        checks++;
        if (ALTDATA1 !== '0) begin errors++; $display("FAIL reset_data1 got=%h exp=0", ALTDATA1); end
        // word presented during a second reset cycle is dropped
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b00) begin errors++; $display("FAIL reset_drop got=%b exp=%b", ALT_INP, 2'b00); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0011) begin errors++; $display("FAIL rr_c0_rdy got=%b exp=%b", req_rdy, 4'b0011); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b11) begin errors++; $display("FAIL rr_c1_alt got=%b exp=%b", ALT_INP, 2'b11); end
        checks++;
        if (ALTDATA0 !== w[0] || ALTDATA1 !== w[1]) begin errors++; $display("FAIL rr_c1_data got=%h/%h exp=%h/%h", ALTDATA0, ALTDATA1, w[0], w[1]); end
        checks++;
        if (req_rdy !== 4'b1100) begin errors++; $display("FAIL rr_c1_rdy got=%b exp=%b", req_rdy, 4'b1100); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b11 || ALTDATA0 !== w[2] || ALTDATA1 !== w[3]) begin errors++; $display("FAIL rr_c2_data got=%b %h/%h exp=11 %h/%h", ALT_INP, ALTDATA0, ALTDATA1, w[2], w[3]); end
        checks++;
        if (req_rdy !== 4'b0011) begin errors++; $display("FAIL rr_c2_rdy got=%b exp=%b", req_rdy, 4'b0011); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b11 || ALTDATA0 !== w[0] || ALTDATA1 !== w[1]) begin errors++; $display("FAIL rr_c3_data got=%b %h/%h exp=11 %h/%h", ALT_INP, ALTDATA0, ALTDATA1, w[0], w[1]); end
    endtask

    // pointer is now 2
    task automatic test_single();
        req_vld = 4'b0100;
        set_word(2, 84'h5A);
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy got=%b exp=%b", req_rdy, 4'b0100); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b01) begin errors++; $display("FAIL single_alt got=%b exp=%b", ALT_INP, 2'b01); end
        checks++;
        if (ALTDATA0 !== 84'h5A) begin errors++; $display("FAIL single_data0 got=%h exp=%h", ALTDATA0, 84'h5A); end
        checks++;
        if (ALTDATA1 !== w[1]) begin errors++; $display("FAIL single_hold1 got=%h exp=%h", ALTDATA1, w[1]); end
    endtask

    // pointer is now 3
    task automatic test_wrap();
        req_vld = 4'b1001;
        set_word(2, w[2]);
        #1;
        checks++;
        if (req_rdy !== 4'b1001) begin errors++; $display("FAIL wrap_rdy got=%b exp=%b", req_rdy, 4'b1001); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b11 || ALTDATA0 !== w[3] || ALTDATA1 !== w[0]) begin errors++; $display("FAIL wrap_data got=%b %h/%h exp=11 %h/%h", ALT_INP, ALTDATA0, ALTDATA1, w[3], w[0]); end
        req_vld = 4'b1111;
        #1;
        checks++;
        if (req_rdy !== 4'b0110) begin errors++; $display("FAIL wrap_ptr_rdy got=%b exp=%b", req_rdy, 4'b0110); end
        next_cycle();
        checks++;
        if (ALTDATA0 !== w[1] || ALTDATA1 !== w[2]) begin errors++; $display("FAIL wrap_ptr_data got=%h/%h exp=%h/%h", ALTDATA0, ALTDATA1, w[1], w[2]); end
    endtask

    // pointer is now 3
    task automatic test_idle();
        req_vld = 4'b0000;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL idle_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b00 || ALTDATA0 !== w[1] || ALTDATA1 !== w[2]) begin errors++; $display("FAIL idle_hold got=%b %h/%h exp=00 %h/%h", ALT_INP, ALTDATA0, ALTDATA1, w[1], w[2]); end
    endtask

    // pointer is 3 and must survive the stall
    task automatic test_stall();
        req_vld = 4'b1111;
        stall   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0000) begin errors++; $display("FAIL stall_rdy c=%0d got=%b exp=%b", c, req_rdy, 4'b0000); end
            next_cycle();
            checks++;
            if (ALT_INP !== 2'b00) begin errors++; $display("FAIL stall_alt c=%0d got=%b exp=%b", c, ALT_INP, 2'b00); end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b1001) begin errors++; $display("FAIL stall_resume_rdy got=%b exp=%b", req_rdy, 4'b1001); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b11 || ALTDATA0 !== w[3] || ALTDATA1 !== w[0]) begin errors++; $display("FAIL stall_resume_data got=%b %h/%h exp=11 %h/%h", ALT_INP, ALTDATA0, ALTDATA1, w[3], w[0]); end
    endtask

    // pointer is now 1
    task automatic test_back_to_back_reset();
        req_vld = 4'b1111;
        #1;
        checks++;
        if (req_rdy !== 4'b0110) begin errors++; $display("FAIL midrst_pre_rdy got=%b exp=%b", req_rdy, 4'b0110); end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL midrst_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        next_cycle();
        checks++;
        if (ALT_INP !== 2'b00 || ALTDATA0 !== '0 || ALTDATA1 !== '0) begin errors++; $display("FAIL midrst_clear got=%b %h/%h exp=00 0/0", ALT_INP, ALTDATA0, ALTDATA1); end
        rst = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0011) begin errors++; $display("FAIL midrst_fresh_rdy got=%b exp=%b", req_rdy, 4'b0011); end
        next_cycle();
        checks++;
        if (ALTDATA0 !== w[0] || ALTDATA1 !== w[1]) begin errors++; $display("FAIL midrst_fresh_data got=%h/%h exp=%h/%h", ALTDATA0, ALTDATA1, w[0], w[1]); end
    endtask

`ifdef FPU_ALT_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        req_vld = 4'b1111;
        stall = 1'b0;
        next_cycle();
        checks++;
        if (perf_grants !== 16'h0 || perf_stalls !== 16'h0) begin errors++; $display("FAIL perf_reset got=%h/%h exp=0/0", perf_grants, perf_stalls); end
        rst = 1'b1;
        stall = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (perf_stalls !== 16'd3 || perf_grants !== 16'd0) begin errors++; $display("FAIL perf_stall3 got=%h/%h exp=3/0", perf_stalls, perf_grants); end
        req_vld = 4'b0000;
        next_cycle();
        checks++;
        if (perf_stalls !== 16'd3) begin errors++; $display("FAIL perf_stall_novld got=%h exp=3", perf_stalls); end
        req_vld = 4'b1111;
        stall = 1'b0;
        repeat (32767) next_cycle();
        checks++;
        if (perf_grants !== 16'hFFFE) begin errors++; $display("FAIL perf_near_sat got=%h exp=fffe", perf_grants); end
        next_cycle();
        checks++;
        if (perf_grants !== 16'hFFFF) begin errors++; $display("FAIL perf_sat got=%h exp=ffff", perf_grants); end
        repeat (5) next_cycle();
        checks++;
        if (perf_grants !== 16'hFFFF) begin errors++; $display("FAIL perf_nowrap got=%h exp=ffff", perf_grants); end
    endtask
`endif

    initial begin
        rst      = 1'b0;
        stall    = 1'b0;
        req_vld  = '0;
        req_data = '0;
        w[0] = 84'hA_0000_0000_0000_0000_1111;
        w[1] = 84'hB_0000_0000_0000_0000_2222;
        w[2] = 84'hC_0000_0000_0000_0000_3333;
        w[3] = 84'hD_0000_0000_0000_0000_4444;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_idle();
        test_stall();
        test_back_to_back_reset();
`ifdef FPU_ALT_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
